// File: rtl/pwm_pkg.sv
// Shared constants and the PWM compare helper for the PWM peripheral.
package pwm_pkg;

  localparam int unsigned PWM_DIV_DEFAULT = 13;
  localparam int unsigned REG_W           = 8;
  localparam logic [REG_W-1:0] DUTY_FULL  = 8'hFF;
  localparam int unsigned NUM_PINS        = 16;

  // Full-scale duty is forced high so the pin never dips for one count at cnt == 255.
  function automatic logic pwm_level(logic [REG_W-1:0] cnt, logic [REG_W-1:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register-bank side of the PWM peripheral: control registers in, pin drive out.
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [REG_W-1:0]    en_reg_out_7_0;
  logic [REG_W-1:0]    en_reg_out_15_8;
  logic [REG_W-1:0]    en_reg_pwm_7_0;
  logic [REG_W-1:0]    en_reg_pwm_15_8;
  logic [REG_W-1:0]    pwm_duty_cycle;
  logic [NUM_PINS-1:0] out;
  logic                period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );

endinterface

// File: rtl/pwm_counter.sv
// Prescaler plus free-running 8-bit PWM counter; flags the period boundary.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = PWM_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [REG_W-1:0] pwm_cnt,
  output logic             boundary,
  output logic             period_start
);

  localparam logic [15:0] PrescMax = 16'(DIV - 1);

  logic [15:0] presc;
  logic        tick;

  assign tick     = (presc == PrescMax);
  assign boundary = tick && (pwm_cnt == '1);

  // Prescaler wraps at DIV-1; counter advances once per tick and wraps 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + 16'd1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      period_start <= boundary;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage: duty shadow, shared compare and per-pin output register.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = PWM_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  logic [REG_W-1:0]    pwm_cnt;
  logic                boundary;
  logic                period_start;
  logic [REG_W-1:0]    duty_shadow;
  logic                pwm_raw;
  logic [NUM_PINS-1:0] oe;
  logic [NUM_PINS-1:0] pe;
  logic [NUM_PINS-1:0] out_q;

  pwm_counter #(
    .DIV (DIV)
  ) u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_cnt      (pwm_cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign oe      = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign pe      = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign pwm_raw = pwm_level(pwm_cnt, duty_shadow);

  // Duty is only sampled at the period boundary so each period is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (boundary) begin
      duty_shadow <= bus.pwm_duty_cycle;
    end
  end

  // Per-pin mux: disabled -> 0, static -> 1, PWM mode -> shared level. Enables are live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= oe & (~pe | {NUM_PINS{pwm_raw}});
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: per-cycle scoreboard plus period measurements.
module tb_pwm_peripheral;
  import pwm_pkg::*;

  localparam int unsigned Div    = 2;
  localparam int          Period = 256 * Div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] oe = '0;
  logic [15:0] pe = '0;
  logic [7:0]  duty = '0;

  pwm_peripheral_if bus ();

  assign bus.en_reg_out_7_0  = oe[7:0];
  assign bus.en_reg_out_15_8 = oe[15:8];
  assign bus.en_reg_pwm_7_0  = pe[7:0];
  assign bus.en_reg_pwm_15_8 = pe[15:8];
  assign bus.pwm_duty_cycle  = duty;

  pwm_peripheral #(
    .DIV (Div)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] out;
    logic        ps;
  } exp_t;

  typedef struct {
    logic [15:0] oe;
    logic [15:0] pe;
    logic [7:0]  duty;
    int          cycles;
    logic [15:0] mask;
    logic [15:0] exp;
  } vec_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         n = 0;          // clock edges since reset release
  logic [7:0] m_shadow = '0;  // duty the model believes is active this period

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Predict the next edge from edge count and duty, then advance one clock and compare.
  task automatic step();
    exp_t       e;
    logic [7:0] cnt;
    logic       raw;
    logic       bnd;
    cnt   = 8'((n / Div) % 256);
    raw   = (m_shadow == 8'hFF) ? 1'b1 : (cnt < m_shadow);
    bnd   = ((n + 1) % Period) == 0;
    e.out = oe & (~pe | {16{raw}});
    e.ps  = bnd;
    sb_q.push_back(e);
    @(posedge clk);
    if (bnd) m_shadow = duty;
    n++;
    #1;
    e = sb_q.pop_front();
    check("sb_out", 32'(bus.out), 32'(e.out));
    check("sb_period_start", 32'(bus.period_start), 32'(e.ps));
  endtask

  task automatic run_to_boundary();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.period_start && k < Period + 1);
    check("boundary_wait", 32'(bus.period_start), 32'd1);
  endtask

  task automatic measure(input int clks, output int highs, output int lows, output bit same);
    highs = 0;
    lows  = 0;
    same  = 1'b1;
    for (int i = 0; i < clks; i++) begin
      step();
      if (bus.out[0]) highs++;
      else lows++;
      if (bus.out != 16'h0000 && bus.out != 16'hFFFF) same = 1'b0;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    m_shadow = '0;
    sb_q.delete();
  endtask

  task automatic first_period_start();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.period_start && k < 2 * Period);
    check("first_period_start_clks", 32'(k), 32'(Period));
  endtask

  vec_t vecs[5];
  int   h1, h2, lo;
  bit   same;

  initial begin
    vecs[0] = '{oe: 16'h0001, pe: 16'h0000, duty: 8'h00, cycles: 10,
                mask: 16'hFFFF, exp: 16'h0001};
    vecs[1] = '{oe: 16'hFFFF, pe: 16'hFF00, duty: 8'h00, cycles: Period + 20,
                mask: 16'h00FF, exp: 16'h00FF};
    vecs[2] = '{oe: 16'h0200, pe: 16'h0600, duty: 8'h80, cycles: 2 * Period,
                mask: 16'hF9FF, exp: 16'h0000};
    vecs[3] = '{oe: 16'h0000, pe: 16'h0600, duty: 8'h80, cycles: 4,
                mask: 16'hFFFF, exp: 16'h0000};
    vecs[4] = '{oe: 16'h00F0, pe: 16'h00C0, duty: 8'hFF, cycles: Period + 20,
                mask: 16'hFF3F, exp: 16'h0030};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("reset_out", 32'(bus.out), 32'h0);
    check("reset_period_start", 32'(bus.period_start), 32'h0);
    repeat (3) @(posedge clk);
    release_reset();

    // All pins PWM at 0x80; the first period still runs at duty 0.
    oe = 16'hFFFF;
    pe = 16'hFFFF;
    duty = 8'h80;
    first_period_start();
    repeat (50) step();
    check("mid_period_high", 32'(bus.out), 32'hFFFF);

    // Asynchronous reset mid-period: outputs drop without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'(bus.out), 32'h0);
    check("async_reset_period_start", 32'(bus.period_start), 32'h0);
    repeat (3) @(negedge clk);
    release_reset();
    first_period_start();

    // Table-driven enable/duty patterns
    for (int v = 0; v < 5; v++) begin
      oe = vecs[v].oe;
      pe = vecs[v].pe;
      duty = vecs[v].duty;
      step();
      check($sformatf("vec%0d_after_1clk", v), 32'(bus.out & vecs[v].mask), 32'(vecs[v].exp));
      for (int c = 1; c < vecs[v].cycles; c++) step();
    end

    // Duty 0x80, all pins: 256 clks high, 256 low, all identical.
    oe = 16'hFFFF;
    pe = 16'hFFFF;
    duty = 8'h80;
    run_to_boundary();
    measure(Period, h1, lo, same);
    check("duty80_high", 32'(h1), 32'(128 * Div));
    check("duty80_low", 32'(lo), 32'(128 * Div));
    check("duty80_in_phase", 32'(same), 32'd1);

    // Extremes
    duty = 8'h00;
    run_to_boundary();
    measure(Period, h1, lo, same);
    check("duty00_high", 32'(h1), 32'd0);
    duty = 8'hFF;
    run_to_boundary();
    measure(2 * Period, h1, lo, same);
    check("dutyFF_low", 32'(lo), 32'd0);

    // Mid-period change is deferred to the next period.
    duty = 8'h40;
    run_to_boundary();
    measure(100, h1, lo, same);
    duty = 8'hC0;
    measure(Period - 100, h2, lo, same);
    check("shadow_old_high", 32'(h1 + h2), 32'(64 * Div));
    check("shadow_ps_at_end", 32'(bus.period_start), 32'd1);
    measure(Period, h1, lo, same);
    check("shadow_new_high", 32'(h1), 32'(192 * Div));

    // Value present on the boundary edge itself is captured.
    measure(Period - 1, h1, lo, same);
    duty = 8'h10;
    step();
    check("edge_ps", 32'(bus.period_start), 32'd1);
    duty = 8'hC0;
    measure(Period, h1, lo, same);
    check("edge_capture_high", 32'(h1), 32'(16 * Div));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
